// File: rtl/keccak_byte_packer_if.sv
// Byte-stream and keccak-core handshake bundle for keccak_byte_packer.
// master = byte source plus core side (testbench), slave = the packer itself.
interface keccak_byte_packer_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        msg_empty;
    logic [63:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [2:0]  k_byte_num;
    logic        k_buffer_full;
    logic        done;

    modport master (
        output s_data, s_valid, s_last, msg_empty, k_buffer_full,
        input  s_ready, k_in, k_in_ready, k_is_last, k_byte_num, done
    );

    modport slave (
        input  s_data, s_valid, s_last, msg_empty, k_buffer_full,
        output s_ready, k_in, k_in_ready, k_is_last, k_byte_num, done
    );
endinterface

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream into 64-bit keccak core words (first byte in [63:56]) and adds the
// zero pad word for 8-byte-multiple messages. KECCAK_BYTE_PACKER_DBUF_EN selects ping-pong slots.
module keccak_byte_packer (
    input  logic                 clk,
    input  logic                 reset,
    keccak_byte_packer_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_FILL          = 3'd0,
        ST_SEND          = 3'd1,
        ST_SEND_THEN_PAD = 3'd2,
        ST_SEND_LAST     = 3'd3,
        ST_DONE          = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] fill_q, fill_d;
    logic        pend_q, pend_d;
    logic        pend_last_q, pend_last_d;
    logic        pend_pad_q, pend_pad_d;
    logic [2:0]  pend_num_q, pend_num_d;
    logic        got_byte_q, got_byte_d;
    logic        last_seen_q, last_seen_d;
    logic        s_ready_q, s_ready_d;
    logic [63:0] k_in_q, k_in_d;
    logic        k_in_ready_q, k_in_ready_d;
    logic        k_is_last_q, k_is_last_d;
    logic [2:0]  k_byte_num_q, k_byte_num_d;
    logic        done_q, done_d;

    logic        acc_s, xfer_s, empty_s, out_free_s;
    logic [5:0]  shamt_s;
    logic [63:0] word_s;
    logic        new_valid_s, new_last_s, new_pad_s;
    logic [2:0]  new_num_s;
    logic [63:0] new_word_s;
    logic        ld_s, ld_last_s, ld_pad_s;
    logic [2:0]  ld_num_s;
    logic [63:0] ld_word_s;

    assign acc_s   = bus.s_valid & s_ready_q;
    assign xfer_s  = k_in_ready_q & ~bus.k_buffer_full;
    assign shamt_s = 6'd56 - {cnt_q, 3'b000};
    assign word_s  = fill_q | ({56'd0, bus.s_data} << shamt_s);
    // A zero-length message is only possible before the first byte of the message.
    assign empty_s = bus.msg_empty & ~acc_s & ~got_byte_q & (state_q == ST_FILL) & (cnt_q == 3'd0);

    // Next-state: output slot handshake, fill slot packing, and hand-over between them.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        pend_d       = pend_q;
        pend_last_d  = pend_last_q;
        pend_pad_d   = pend_pad_q;
        pend_num_d   = pend_num_q;
        got_byte_d   = got_byte_q;
        last_seen_d  = last_seen_q;
        k_in_d       = k_in_q;
        k_in_ready_d = k_in_ready_q;
        k_is_last_d  = k_is_last_q;
        k_byte_num_d = k_byte_num_q;
        done_d       = done_q;
        out_free_s   = 1'b0;

        case (state_q)
            ST_FILL: out_free_s = 1'b1;
            ST_SEND: begin
                if (xfer_s) begin
                    out_free_s   = 1'b1;
                    state_d      = ST_FILL;
                    k_in_d       = 64'd0;
                    k_in_ready_d = 1'b0;
                end else begin
                    out_free_s   = 1'b0;
                end
            end
            ST_SEND_THEN_PAD: begin
                if (xfer_s) begin
                    state_d      = ST_SEND_LAST;
                    k_in_d       = 64'd0;
                    k_is_last_d  = 1'b1;
                    k_byte_num_d = 3'd0;
                end else begin
                    state_d      = ST_SEND_THEN_PAD;
                end
            end
            ST_SEND_LAST: begin
                if (xfer_s) begin
                    state_d      = ST_DONE;
                    k_in_d       = 64'd0;
                    k_in_ready_d = 1'b0;
                    k_is_last_d  = 1'b0;
                    k_byte_num_d = 3'd0;
                    done_d       = 1'b1;
                end else begin
                    state_d      = ST_SEND_LAST;
                end
            end
            ST_DONE: done_d = 1'b1;
            default: state_d = ST_FILL;
        endcase

        new_valid_s = 1'b0;
        new_word_s  = 64'd0;
        new_last_s  = 1'b0;
        new_pad_s   = 1'b0;
        new_num_s   = 3'd0;
        if (acc_s) begin
            got_byte_d = 1'b1;
            if ((cnt_q == 3'd7) || bus.s_last) begin
                new_valid_s = 1'b1;
                new_word_s  = word_s;
                new_last_s  = bus.s_last & (cnt_q != 3'd7);
                new_pad_s   = bus.s_last & (cnt_q == 3'd7);
                new_num_s   = (bus.s_last && (cnt_q != 3'd7)) ? (cnt_q + 3'd1) : 3'd0;
                cnt_d       = 3'd0;
                last_seen_d = bus.s_last;
            end else begin
                cnt_d       = cnt_q + 3'd1;
                fill_d      = word_s;
            end
        end else if (empty_s) begin
            new_valid_s = 1'b1;
            new_last_s  = 1'b1;
            last_seen_d = 1'b1;
        end else begin
            got_byte_d  = got_byte_q;
        end

        // A parked word always has priority; bytes are never accepted while one is parked.
        ld_s      = 1'b0;
        ld_word_s = 64'd0;
        ld_last_s = 1'b0;
        ld_pad_s  = 1'b0;
        ld_num_s  = 3'd0;
        if (out_free_s && pend_q) begin
            ld_s      = 1'b1;
            ld_word_s = fill_q;
            ld_last_s = pend_last_q;
            ld_pad_s  = pend_pad_q;
            ld_num_s  = pend_num_q;
            pend_d    = 1'b0;
            fill_d    = 64'd0;
        end else if (new_valid_s && out_free_s) begin
            ld_s      = 1'b1;
            ld_word_s = new_word_s;
            ld_last_s = new_last_s;
            ld_pad_s  = new_pad_s;
            ld_num_s  = new_num_s;
            fill_d    = 64'd0;
        end else if (new_valid_s) begin
            pend_d      = 1'b1;
            fill_d      = new_word_s;
            pend_last_d = new_last_s;
            pend_pad_d  = new_pad_s;
            pend_num_d  = new_num_s;
        end else begin
            pend_d      = pend_q;
        end

        if (ld_s) begin
            k_in_d       = ld_word_s;
            k_in_ready_d = 1'b1;
            k_is_last_d  = ld_last_s;
            k_byte_num_d = ld_num_s;
            if (ld_pad_s) begin
                state_d = ST_SEND_THEN_PAD;
            end else if (ld_last_s) begin
                state_d = ST_SEND_LAST;
            end else begin
                state_d = ST_SEND;
            end
        end else begin
            k_in_ready_d = k_in_ready_d;
        end

`ifdef KECCAK_BYTE_PACKER_DBUF_EN
        s_ready_d = (state_d != ST_DONE) & ~last_seen_d & ~pend_d;
`else
        s_ready_d = (state_d == ST_FILL) & ~last_seen_d;
`endif
    end

    // State and registered outputs; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FILL;
            cnt_q        <= 3'd0;
            fill_q       <= 64'd0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_pad_q   <= 1'b0;
            pend_num_q   <= 3'd0;
            got_byte_q   <= 1'b0;
            last_seen_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            k_in_q       <= 64'd0;
            k_in_ready_q <= 1'b0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= 3'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            pend_pad_q   <= pend_pad_d;
            pend_num_q   <= pend_num_d;
            got_byte_q   <= got_byte_d;
            last_seen_q  <= last_seen_d;
            s_ready_q    <= s_ready_d;
            k_in_q       <= k_in_d;
            k_in_ready_q <= k_in_ready_d;
            k_is_last_q  <= k_is_last_d;
            k_byte_num_q <= k_byte_num_d;
            done_q       <= done_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.k_in       = k_in_q;
    assign bus.k_in_ready = k_in_ready_q;
    assign bus.k_is_last  = k_is_last_q;
    assign bus.k_byte_num = k_byte_num_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_keccak_byte_packer.sv
// Randomized self-checking bench for keccak_byte_packer against a chunk-and-pad message model.
module tb_keccak_byte_packer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct packed {
        logic [63:0] w;
        logic        last;
        logic [2:0]  num;
    } word_t;

    logic [7:0] msg_q[$];
    word_t      exp_q[$];
    word_t      got_q[$];

    keccak_byte_packer_if bus();

    keccak_byte_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected word list: 8-byte chunks; a short tail is the last word, else an extra zero word.
    function automatic void build_expected();
        int len;
        len = msg_q.size();
        exp_q.delete();
        for (int base = 0; base < len; base += 8) begin
            word_t e;
            int    n;
            e.w = 64'd0;
            n   = len - base;
            for (int j = 0; j < 8 && base + j < len; j++) e.w[63-8*j -: 8] = msg_q[base+j];
            e.last = (n < 8);
            e.num  = (n < 8) ? n[2:0] : 3'd0;
            exp_q.push_back(e);
        end
        if (len % 8 == 0) exp_q.push_back({64'd0, 1'b1, 3'd0});
    endfunction

    function automatic void load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endfunction

    task automatic do_reset(input string name);
        reset = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.s_last = 1'b0;
        bus.msg_empty = 1'b0; bus.k_buffer_full = 1'b0;
        @(negedge clk);
        check_eq({name, ":rst_s_ready"},    bus.s_ready,    64'd0);
        check_eq({name, ":rst_k_in"},       bus.k_in,       64'd0);
        check_eq({name, ":rst_k_in_ready"}, bus.k_in_ready, 64'd0);
        check_eq({name, ":rst_k_is_last"},  bus.k_is_last,  64'd0);
        check_eq({name, ":rst_k_byte_num"}, bus.k_byte_num, 64'd0);
        check_eq({name, ":rst_done"},       bus.done,       64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq({name, ":s_ready_after_rst"}, bus.s_ready, 64'd1);
    endtask

    task automatic feed_partial(input int n);
        int acc_n = 0;
        int cyc   = 0;
        bus.s_last = 1'b0;
        while (acc_n < n && cyc < 100) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'h30 + acc_n[7:0];
            if (bus.s_ready) acc_n++;
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        check_eq("partial_fed", acc_n, n);
    endtask

    // bp_mode: 0 none, 1 random, 2 hold buffer_full for 3 cycles on every word.
    task automatic run_msg(input string name, input int valid_pct, input int bp_mode);
        int    len, idx, cyc, hold;
        logic  bf, prev_stall, empty_sent;
        word_t saved;
        len = msg_q.size();
        build_expected();
        got_q.delete();
        do_reset(name);
        idx = 0; cyc = 0; hold = 0; prev_stall = 1'b0; empty_sent = 1'b0;
        saved = '0;
        while (!bus.done && cyc < 2000) begin
            if (prev_stall) begin
                check_eq({name, ":hold_k_in"},       bus.k_in,       saved.w);
                check_eq({name, ":hold_k_is_last"},  bus.k_is_last,  saved.last);
                check_eq({name, ":hold_k_byte_num"}, bus.k_byte_num, saved.num);
                check_eq({name, ":hold_k_in_ready"}, bus.k_in_ready, 64'd1);
            end
            if (!bus.k_is_last) check_eq({name, ":num_zero_not_last"}, bus.k_byte_num, 64'd0);
`ifndef KECCAK_BYTE_PACKER_DBUF_EN
            if (bus.k_in_ready) check_eq({name, ":s_ready_in_send"}, bus.s_ready, 64'd0);
`endif
            case (bp_mode)
                1: bf = ($urandom_range(0, 99) < 40);
                2: begin
                    if (bus.k_in_ready && hold < 3) begin bf = 1'b1; hold++; end
                    else bf = 1'b0;
                end
                default: bf = 1'b0;
            endcase
            bus.k_buffer_full = bf;
            if (bus.k_in_ready && !bf) begin
                got_q.push_back({bus.k_in, bus.k_is_last, bus.k_byte_num});
                hold = 0;
            end
            prev_stall = bus.k_in_ready && bf;
            saved      = {bus.k_in, bus.k_is_last, bus.k_byte_num};

            bus.msg_empty = 1'b0;
            if (len == 0) begin
                bus.s_valid = 1'b0;
                if (!empty_sent && $urandom_range(0, 3) == 0) begin
                    bus.msg_empty = 1'b1;
                    empty_sent    = 1'b1;
                end
            end else if (idx < len && $urandom_range(0, 99) < valid_pct) begin
                bus.s_valid = 1'b1;
                bus.s_data  = msg_q[idx];
                bus.s_last  = (idx == len - 1);
                if (bus.s_ready) begin
                    idx++;
                    if ($urandom_range(0, 9) == 0) bus.msg_empty = 1'b1;
                end
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                bus.s_last  = 1'($urandom);
                if (idx > 0 && $urandom_range(0, 9) == 0) bus.msg_empty = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0; bus.msg_empty = 1'b0; bus.k_buffer_full = 1'b0;
        check_eq({name, ":done"},       bus.done,     64'd1);
        check_eq({name, ":word_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s:w%0d_k_in", name, i),     got_q[i].w,    exp_q[i].w);
            check_eq($sformatf("%s:w%0d_is_last", name, i),  got_q[i].last, exp_q[i].last);
            check_eq($sformatf("%s:w%0d_byte_num", name, i), got_q[i].num,  exp_q[i].num);
        end
        @(negedge clk);
        check_eq({name, ":done_sticky"},     bus.done,       64'd1);
        check_eq({name, ":done_s_ready"},    bus.s_ready,    64'd0);
        check_eq({name, ":done_k_in_ready"}, bus.k_in_ready, 64'd0);
    endtask

    task automatic check_final(input string name, input logic [63:0] w, input logic [2:0] num);
        check_eq({name, ":final_seen"}, (got_q.size() > 0), 64'd1);
        if (got_q.size() > 0) begin
            check_eq({name, ":final_k_in"},     got_q[got_q.size()-1].w,    w);
            check_eq({name, ":final_byte_num"}, got_q[got_q.size()-1].num,  num);
            check_eq({name, ":final_is_last"},  got_q[got_q.size()-1].last, 64'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.s_last = 1'b0;
        bus.msg_empty = 1'b0; bus.k_buffer_full = 1'b0;

        load_str("The quick brown fox jumps over the lazy dog");
        run_msg("fox", 100, 0);
        check_eq("fox:first_k_in", (got_q.size() > 0) ? got_q[0].w : 64'd0, 64'h5468652071756963);
        check_final("fox", 64'h646F670000000000, 3'd3);

        load_str("The quick brown fox jumps over the lazy dog.");
        run_msg("fox_dot", 100, 0);
        check_final("fox_dot", 64'h646F672E00000000, 3'd4);

        load_str("The quic");
        run_msg("quic", 100, 0);
        check_eq("quic:first_k_in", (got_q.size() > 0) ? got_q[0].w : 64'd0, 64'h5468652071756963);
        check_final("quic", 64'd0, 3'd0);

        msg_q.delete();
        run_msg("empty", 100, 0);
        check_final("empty", 64'd0, 3'd0);

        load_str("The quick brown fox jumps over the lazy dog");
        run_msg("fox_bp", 100, 2);

        do_reset("mid");
        feed_partial(5);
        load_str("abc");
        run_msg("abc", 100, 0);
        check_final("abc", 64'h6162630000000000, 3'd3);

        for (int t = 0; t < 14; t++) begin
            int len;
            len = (t == 0) ? 16 : $urandom_range(0, 40);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            run_msg($sformatf("rnd%0d", t), $urandom_range(50, 100), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
